// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: regenerates the 65C02 PHI2 clock from the divided source clock.
//   The divided clock is synchronised into clk_in, and PHI2 is rebuilt from its edges.
//   A high phase may only start on a source rise when RDY is high and the CPU is either
//   free-running or holding a debounced single-step token. Once started, a phase always
//   runs for the full source high time.
// Ports:
//   clk_in       system clock, sole clock of the block
//   rst          asynchronous, active-high reset
//   cpu_clk_src  divided clock from the divider (asynchronous)
//   run_mode     1 = free run, 0 = halted / single-step
//   step_btn     raw single-step button, active-high, bouncy
//   rdy_in       1 = a cycle may start, 0 = hold PHI2 low (wait state)
//   phi2         regenerated CPU clock
//   phi2_rise    one-cycle pulse in the first cycle phi2 reads 1
//   phi2_fall    one-cycle pulse in the first cycle phi2 reads 0
//   halted       phi2 low and no cycle can start
//   cycle_count  PHI2 high phases started since reset (wraps)
module cpu_clock_ctrl #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        cpu_clk_src,
  input  logic        run_mode,
  input  logic        step_btn,
  input  logic        rdy_in,
  output logic        phi2,
  output logic        phi2_rise,
  output logic        phi2_fall,
  output logic        halted,
  output logic [31:0] cycle_count
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  // Synchroniser chains, LSB is the first stage
  logic [SYNC_STAGES-1:0] r_src_sync;
  logic [SYNC_STAGES-1:0] r_run_sync;
  logic [SYNC_STAGES-1:0] r_step_sync;
  logic [SYNC_STAGES-1:0] r_rdy_sync;

  logic w_src_s;
  logic w_run_s;
  logic w_step_s;
  logic w_rdy_s;

  assign w_src_s  = r_src_sync[SYNC_STAGES-1];
  assign w_run_s  = r_run_sync[SYNC_STAGES-1];
  assign w_step_s = r_step_sync[SYNC_STAGES-1];
  assign w_rdy_s  = r_rdy_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_src_sync  <= '0;
      r_run_sync  <= '0;
      r_step_sync <= '0;
      r_rdy_sync  <= '0;
    end else begin
      r_src_sync  <= {r_src_sync[SYNC_STAGES-2:0], cpu_clk_src};
      r_run_sync  <= {r_run_sync[SYNC_STAGES-2:0], run_mode};
      r_step_sync <= {r_step_sync[SYNC_STAGES-2:0], step_btn};
      r_rdy_sync  <= {r_rdy_sync[SYNC_STAGES-2:0], rdy_in};
    end
  end

  // Source edge strobes, registered so a source edge reaches phi2 three clocks after sampling
  logic r_src_d;
  logic r_src_rise;
  logic r_src_fall;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_src_d    <= 1'b0;
      r_src_rise <= 1'b0;
      r_src_fall <= 1'b0;
    end else begin
      r_src_d    <= w_src_s;
      r_src_rise <= w_src_s & ~r_src_d;
      r_src_fall <= ~w_src_s & r_src_d;
    end
  end

  // Step debounce: the stable value only follows after DEBOUNCE_CYCLES consecutive differing samples
  logic            r_step_stable;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_db_done;
  logic            w_step_event;

  assign w_db_done    = (w_step_s != r_step_stable) && (r_db_cnt == DB_LAST);
  assign w_step_event = w_db_done & w_step_s;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_step_stable <= 1'b0;
      r_db_cnt      <= '0;
    end else if (w_step_s == r_step_stable) begin
      r_db_cnt <= '0;
    end else if (w_db_done) begin
      r_step_stable <= w_step_s;
      r_db_cnt      <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  // PHI2 FSM state and registered outputs
  state_t      r_state;
  logic        r_phi2;
  logic        r_rise;
  logic        r_fall;
  logic        r_halted;
  logic        r_step_pending;
  logic [31:0] r_cycle_count;

  state_t      w_state_nxt;
  logic        w_phi2_nxt;
  logic        w_rise_nxt;
  logic        w_fall_nxt;
  logic        w_halted_nxt;
  logic        w_pend_nxt;
  logic        w_grant;
  logic [31:0] w_count_nxt;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state        <= ST_LOW;
      r_phi2         <= 1'b0;
      r_rise         <= 1'b0;
      r_fall         <= 1'b0;
      r_halted       <= 1'b1;
      r_step_pending <= 1'b0;
      r_cycle_count  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_phi2         <= w_phi2_nxt;
      r_rise         <= w_rise_nxt;
      r_fall         <= w_fall_nxt;
      r_halted       <= w_halted_nxt;
      r_step_pending <= w_pend_nxt;
      r_cycle_count  <= w_count_nxt;
    end
  end

  // Next-state: a rise is granted or skipped whole; a started phase only ends on the source fall
  always_comb begin
    w_state_nxt = r_state;
    w_phi2_nxt  = r_phi2;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_count_nxt = r_cycle_count;
    w_pend_nxt  = r_step_pending;
    w_grant     = 1'b0;

    case (r_state)
      ST_LOW: begin
        if (r_src_rise && w_rdy_s && (w_run_s || r_step_pending)) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_HIGH;
          w_phi2_nxt  = 1'b1;
          w_rise_nxt  = 1'b1;
          w_count_nxt = r_cycle_count + 32'd1;
        end
      end
      ST_HIGH: begin
        if (r_src_fall) begin
          w_state_nxt = ST_LOW;
          w_phi2_nxt  = 1'b0;
          w_fall_nxt  = 1'b1;
        end
      end
    endcase

    // Grant consumes the old token first so a same-cycle step event re-arms it
    if (w_grant) begin
      w_pend_nxt = 1'b0;
    end
    if (w_run_s) begin
      w_pend_nxt = 1'b0;
    end else if (w_step_event) begin
      w_pend_nxt = 1'b1;
    end

    w_halted_nxt = (w_state_nxt == ST_LOW) & ~w_run_s & ~w_pend_nxt;
  end

  assign phi2        = r_phi2;
  assign phi2_rise   = r_rise;
  assign phi2_fall   = r_fall;
  assign halted      = r_halted;
  assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: checks cpu_clock_ctrl against a latency-based reference model of the
// PHI2 grant rules, plus phase-level checks for halt, single-step, RDY wait and wrap/reset.
module tb_cpu_clock_ctrl;

  localparam int HALF = 13;
  localparam int HMAX = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_clk_src = 1'b0;
  logic        run_mode = 1'b0;
  logic        step_btn = 1'b0;
  logic        rdy_in = 1'b0;
  logic        phi2;
  logic        phi2_rise;
  logic        phi2_fall;
  logic        halted;
  logic [31:0] cycle_count;

  cpu_clock_ctrl #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk_in     (clk),
    .rst        (rst),
    .cpu_clk_src(cpu_clk_src),
    .run_mode   (run_mode),
    .step_btn   (step_btn),
    .rdy_in     (rdy_in),
    .phi2       (phi2),
    .phi2_rise  (phi2_rise),
    .phi2_fall  (phi2_fall),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Input history indexed by clock edge number since reset release (edge 0 and earlier read 0)
  logic src_at [HMAX];
  logic run_at [HMAX];
  logic rdy_at [HMAX];
  int   e;
  int   src_cnt;
  bit   chk_en;

  // Reference model state
  bit          m_high;
  logic [31:0] m_count;
  bit          exp_rise;
  bit          exp_fall;
  bit          exp_halted;

  // Phase measurement
  int   rise_cnt;
  int   fall_cnt;
  int   run_len;
  int   last_high_len;
  int   last_low_len;
  logic prev_phi2;

  function automatic logic hist(input int which, input int i);
    if (i <= 0 || i >= HMAX) return 1'b0;
    case (which)
      0:       return src_at[i];
      1:       return run_at[i];
      default: return rdy_at[i];
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < HMAX; i++) begin
      src_at[i] = 1'b0;
      run_at[i] = 1'b0;
      rdy_at[i] = 1'b0;
    end
    e             = 0;
    m_high        = 1'b0;
    m_count       = 32'd0;
    rise_cnt      = 0;
    fall_cnt      = 0;
    run_len       = 0;
    last_high_len = 0;
    last_low_len  = 0;
    prev_phi2     = 1'b0;
  endtask

  // Source edges act three edges after sampling; run/rdy levels are seen two edges after sampling
  task automatic model_edge();
    logic s_rise;
    logic s_fall;
    s_rise   = hist(0, e - 3) & ~hist(0, e - 4);
    s_fall   = ~hist(0, e - 3) & hist(0, e - 4);
    exp_rise = 1'b0;
    exp_fall = 1'b0;
    if (!m_high) begin
      if (s_rise && hist(2, e - 2) && hist(1, e - 2)) begin
        m_high   = 1'b1;
        exp_rise = 1'b1;
        m_count  = m_count + 32'd1;
      end
    end else if (s_fall) begin
      m_high   = 1'b0;
      exp_fall = 1'b1;
    end
    exp_halted = !m_high && !hist(1, e - 2);
  endtask

  task automatic compare_outputs();
    checks++;
    if (phi2 !== m_high) begin
      errors++;
      $display("FAIL edge%0d phi2 got %b expected %b", e, phi2, m_high);
    end
    checks++;
    if (phi2_rise !== exp_rise) begin
      errors++;
      $display("FAIL edge%0d phi2_rise got %b expected %b", e, phi2_rise, exp_rise);
    end
    checks++;
    if (phi2_fall !== exp_fall) begin
      errors++;
      $display("FAIL edge%0d phi2_fall got %b expected %b", e, phi2_fall, exp_fall);
    end
    checks++;
    if (halted !== exp_halted) begin
      errors++;
      $display("FAIL edge%0d halted got %b expected %b", e, halted, exp_halted);
    end
    checks++;
    if (cycle_count !== m_count) begin
      errors++;
      $display("FAIL edge%0d cycle_count got %0d expected %0d", e, cycle_count, m_count);
    end
  endtask

  // One clk_in cycle: record inputs at the edge, check at the falling edge, then drive the next inputs
  task automatic tick();
    @(posedge clk);
    if (e < HMAX - 1) e++;
    src_at[e] = cpu_clk_src;
    run_at[e] = run_mode;
    rdy_at[e] = rdy_in;
    model_edge();
    @(negedge clk);
    if (chk_en) compare_outputs();
    if (phi2_rise === 1'b1) rise_cnt++;
    if (phi2_fall === 1'b1) fall_cnt++;
    if (phi2 !== prev_phi2) begin
      if (prev_phi2 === 1'b1) last_high_len = run_len;
      else last_low_len = run_len;
      run_len   = 1;
      prev_phi2 = phi2;
    end else begin
      run_len++;
    end
    src_cnt++;
    if (src_cnt == HALF) begin
      src_cnt     = 0;
      cpu_clk_src = ~cpu_clk_src;
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_rise(input string name, input int limit);
    for (int i = 0; i < limit && phi2_rise !== 1'b1; i++) tick();
    check_val(name, 32'(phi2_rise), 32'd1);
  endtask

  task automatic wait_fall(input string name, input int limit);
    for (int i = 0; i < limit && phi2_fall !== 1'b1; i++) tick();
    check_val(name, 32'(phi2_fall), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_phi2"}, 32'(phi2), 32'd0);
    check_val({tag, "_rise"}, 32'(phi2_rise), 32'd0);
    check_val({tag, "_fall"}, 32'(phi2_fall), 32'd0);
    check_val({tag, "_count"}, cycle_count, 32'd0);
    check_val({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic test_reset();
    chk_en = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    run_mode    = 1'b1;
    rdy_in      = 1'b1;
    cpu_clk_src = 1'b0;
    src_cnt     = 0;
    model_reset();
    chk_en = 1'b1;
    rst    = 1'b0;
  endtask

  task automatic test_free_run();
    rise_cnt = 0;
    fall_cnt = 0;
    repeat (266) tick();
    check_val("free_count", cycle_count, 32'd10);
    check_val("free_rises", 32'(rise_cnt), 32'd10);
    check_val("free_falls", 32'(fall_cnt), 32'd10);
    check_val("free_high_len", 32'(last_high_len), 32'd13);
    check_val("free_low_len", 32'(last_low_len), 32'd13);
  endtask

  task automatic test_halt();
    logic [31:0] frozen;
    for (int i = 0; i < 40 && phi2 !== 1'b1; i++) tick();
    check_val("halt_phi2_high", 32'(phi2), 32'd1);
    run_mode = 1'b0;
    frozen   = m_count;
    rise_cnt = 0;
    repeat (80) tick();
    check_val("halt_high_len", 32'(last_high_len), 32'd13);
    check_val("halt_rises", 32'(rise_cnt), 32'd0);
    check_val("halt_count", cycle_count, frozen);
    check_val("halt_halted", 32'(halted), 32'd1);
    check_val("halt_phi2", 32'(phi2), 32'd0);
  endtask

  task automatic test_step();
    bit          pat [17];
    logic [31:0] base;
    pat    = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    chk_en = 1'b0;
    base   = m_count;
    rise_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      step_btn = pat[i];
      tick();
    end
    repeat (100) tick();
    check_val("step_phases", 32'(rise_cnt), 32'd1);
    check_val("step_high_len", 32'(last_high_len), 32'd13);
    check_val("step_count", cycle_count, base + 32'd1);
    check_val("step_halted", 32'(halted), 32'd1);
    check_val("step_phi2", 32'(phi2), 32'd0);
    // A 2-cycle glitch is shorter than the debounce window
    rise_cnt = 0;
    step_btn = 1'b1;
    tick();
    tick();
    step_btn = 1'b0;
    repeat (60) tick();
    check_val("glitch_phases", 32'(rise_cnt), 32'd0);
    check_val("glitch_count", cycle_count, base + 32'd1);
    check_val("glitch_halted", 32'(halted), 32'd1);
    m_count = base + 32'd1;
    m_high  = 1'b0;
    chk_en  = 1'b1;
  endtask

  task automatic test_rdy_wait();
    run_mode = 1'b1;
    wait_fall("rdy_wait_fall", 80);
    rdy_in = 1'b0;
    repeat (30) tick();
    rdy_in = 1'b1;
    wait_rise("rdy_wait_rise", 60);
    check_val("rdy_low_len", 32'(last_low_len), 32'd39);
    repeat (14) tick();
    check_val("rdy_next_high_len", 32'(last_high_len), 32'd13);
  endtask

  task automatic test_wrap_and_reset();
    wait_fall("wrap_wait_fall", 60);
    force dut.r_cycle_count = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick();
    tick();
    release dut.r_cycle_count;
    wait_rise("wrap_wait_rise", 40);
    check_val("wrap_count", cycle_count, 32'd0);
    repeat (4) tick();
    check_val("mid_high_phi2", 32'(phi2), 32'd1);
    // Reset lands between clock edges and must act immediately
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_random();
    run_mode = 1'b1;
    rdy_in   = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) run_mode = ~run_mode;
      if ($urandom_range(0, 14) == 0) rdy_in = ~rdy_in;
      tick();
    end
  endtask

  initial begin
    model_reset();
    chk_en  = 1'b0;
    src_cnt = 0;
    test_reset();
    test_free_run();
    test_halt();
    test_step();
    test_rdy_wait();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
Sits directly downstream of the clock divider and turns its divided output into the 65C02 PHI2 clock.
- Synchronises the divided clock into the system clock domain and regenerates PHI2 from its edges.
- Gates PHI2 with run/halt, debounced single-step and RDY controls.
- Emits one-cycle edge strobes and a CPU cycle count for the bus/memory logic and debug.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on cpu_clk_src, step_btn, run_mode and rdy_in (min 2)
DEBOUNCE_CYCLES, 270000, clk_in cycles step_btn must be stable before it is accepted (10 ms at 27 MHz)

Ports:
clk_in  input  1  system clock; sole clock of the block
rst  input  1  asynchronous, active-high reset
cpu_clk_src  input  1  divided clock from the divider; treated as asynchronous
run_mode  input  1  1 = free run, 0 = halted/single-step
step_btn  input  1  raw single-step button, active-high, bouncy
rdy_in  input  1  1 = cycle may start, 0 = hold PHI2 low (wait state)
phi2  output  1  regenerated CPU clock, registered
phi2_rise  output  1  one-clk_in pulse, asserted in the cycle phi2 first reads 1
phi2_fall  output  1  one-clk_in pulse, asserted in the cycle phi2 first reads 0
halted  output  1  1 when phi2 is low and no cycle can start (run_mode=0, no step pending)
cycle_count  output  32  number of PHI2 high phases started since reset

Behaviour:
- Interface: one clock, clk_in. Reset rst is asynchronous and active-high; all flops clear on rst=1 without waiting for a clock edge.
- Reset values: phi2=0, phi2_rise=0, phi2_fall=0, cycle_count=0, step_pending=0, debounce counter=0, state=LOW. Synchronisers clear to 0.
  - halted reads 1 in reset, because run_mode_sync=0.
  - phi2 may be cut short by a reset asserted mid-high phase; this is accepted.
- Synchronisers:
  - Each async input passes through SYNC_STAGES flops.
  - src_rise = src_sync & ~src_d; src_fall = ~src_sync & src_d, where src_d is src_sync delayed one cycle.
- Latency: with SYNC_STAGES=2, a cpu_clk_src edge sampled at clk_in edge k produces the phi2 change at edge k+3.
- FSM, two states:
  - LOW (phi2=0): on src_rise, if rdy_sync=1 and (run_sync=1 or step_pending=1), then go to HIGH, set phi2=1, pulse phi2_rise, increment cycle_count (wraps modulo 2^32) and clear step_pending. Otherwise stay in LOW and ignore that src_rise; the next chance is the next src_rise (RDY stretches the low phase by whole source periods).
  - HIGH (phi2=1): on src_fall, go to LOW, set phi2=0 and pulse phi2_fall. run_mode, rdy_in and step changes during HIGH do not shorten the phase.
- Duty cycle: a granted phase follows the source, so phi2 high time equals source high time; with divisor 13, phi2 is 13 cycles high and 13 low.
- Debounce:
  - A counter resets whenever step_sync equals the stable value.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1, the stable value takes step_sync and the counter clears.
  - A stable 0→1 transition is a step event.
- Step token:
  - A step event sets step_pending (single token, saturating); extra presses before consumption are lost.
  - While run_sync=1, step events are ignored and step_pending is cleared.
  - If a step event and a grant occur in the same cycle, the grant consumes the old token and the new event sets step_pending again, so the token is not lost.
- halted = (state==LOW) & ~run_sync & ~step_pending, registered from the next-state values.
- phi2_rise and phi2_fall are never asserted in the same cycle.

Test Plan:
- Reset then free run. Stimulus: rst pulse; cpu_clk_src toggling every 13 clk_in cycles; run_mode=1; rdy_in=1. Required: phi2 rises 3 cycles after each source rise and is 13 high / 13 low; after 10 source periods cycle_count=10; exactly one phi2_rise and one phi2_fall per period.
- Halt. Stimulus: run_mode 1→0 while phi2 is high. Required: the high phase completes at full length (13 cycles); phi2 then stays 0; halted=1; cycle_count frozen.
- Single step. Stimulus: DEBOUNCE_CYCLES=4, run_mode=0; step_btn pulse 10 cycles with bounces of 1–2 cycles at the start. Required: exactly one phi2 high phase of 13 cycles; cycle_count +1; halted returns to 1. A 2-cycle glitch produces no step.
- RDY wait. Stimulus: free run; rdy_in=0 for 30 cycles covering one source rise. Required: that slot is skipped, so phi2 stays low for 39 cycles; the next slot is granted normally.
- Wrap and async reset. Stimulus: force cycle_count=32'hFFFF_FFFF, then one grant; then assert rst mid-high without a clock edge. Required: cycle_count=0 after the grant; on rst, phi2 drops to 0 and all outputs take their reset values immediately.
